// File: rtl/seven_segment_scanner_pkg.sv
// Shared types and constants for the seven-segment scanner.
//   scan_state_t  : scan FSM states (OFF / BLANK / SHOW)
//   SEG_DARK      : all cathodes off, {point, G..A} active-low
//   SEG_GLYPH_OFF : G..A off, point bit excluded
package seven_segment_scanner_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  localparam logic [7:0] SEG_DARK      = 8'hFF;
  localparam logic [6:0] SEG_GLYPH_OFF = 7'h7F;

endpackage

// File: rtl/seven_segment_scanner_encoder.sv
// SevenSegmentEncoder: hex nibble to active-low G..A segment pattern.
//   nibble   in  [3:0]  hex digit
//   segments out [6:0]  {G,F,E,D,C,B,A}, 0 = segment lit
module SevenSegmentEncoder (
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  always_comb begin
    segments = 7'h7F;
    case (nibble)
      4'h0: segments = 7'h40;
      4'h1: segments = 7'h79;
      4'h2: segments = 7'h24;
      4'h3: segments = 7'h30;
      4'h4: segments = 7'h19;
      4'h5: segments = 7'h12;
      4'h6: segments = 7'h02;
      4'h7: segments = 7'h78;
      4'h8: segments = 7'h00;
      4'h9: segments = 7'h10;
      4'hA: segments = 7'h08;
      4'hB: segments = 7'h03;
      4'hC: segments = 7'h46;
      4'hD: segments = 7'h21;
      4'hE: segments = 7'h06;
      4'hF: segments = 7'h0E;
      default: segments = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment display scanner with anti-ghosting blank slots
// and frame-aligned (tear-free) data commit.
//   clk, reset          : clock, synchronous active-high reset
//   enable              : scan enable, low forces the display dark
//   value, pointEnable  : hex nibbles (digit 0 rightmost) and decimal points
//   load                : one-cycle strobe capturing value/pointEnable
//   loadBusy            : captured data is waiting for the next commit
//   segmentEnableN      : registered active-low {point, G..A}
//   digitEnableN        : registered active-low anodes, at most one low
//   frameStart          : one-cycle pulse at each commit point
// Optional: define SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN to blank leading zeros.
module seven_segment_scanner
  import seven_segment_scanner_pkg::*;
#(
  parameter int DIGIT_COUNT    = 4,
  parameter int REFRESH_DIVIDE = 50000,
  parameter int BLANK_CYCLES   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [4*DIGIT_COUNT-1:0] value,
  input  logic [DIGIT_COUNT-1:0]   pointEnable,
  input  logic                     load,
  output logic                     loadBusy,
  output logic [7:0]               segmentEnableN,
  output logic [DIGIT_COUNT-1:0]   digitEnableN,
  output logic                     frameStart
);

  localparam int IW = $clog2(DIGIT_COUNT);
  localparam int CW = $clog2(REFRESH_DIVIDE);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIVIDE - BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGIT_COUNT - 1);

  scan_state_t                 state;
  logic [IW-1:0]               idx, idx_next;
  logic [CW-1:0]               cnt;
  logic [DIGIT_COUNT-1:0][3:0] pend_value, disp_value;
  logic [DIGIT_COUNT-1:0]      pend_point, disp_point, blank_mask;
  logic [6:0]                  glyph;
  logic [7:0]                  seg_show;
  logic                        slot_end, commit;

  assign idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
  assign slot_end = (state == ST_SHOW) && (cnt == SHOW_LAST);
  // Every entry into BLANK with index 0 is a frame boundary: from OFF, or
  // leaving the last digit's SHOW slot.
  assign commit   = enable && ((state == ST_OFF) || (slot_end && (idx_next == '0)));

  SevenSegmentEncoder u_enc (
    .nibble   (disp_value[idx]),
    .segments (glyph)
  );

`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
  logic upper_zero;
  // Walk down from the top digit; a digit is blanked while it and all above
  // it are zero. Digit 0 always shows.
  always_comb begin
    upper_zero = 1'b1;
    blank_mask = '0;
    for (int i = DIGIT_COUNT - 1; i > 0; i--) begin
      upper_zero    = upper_zero && (disp_value[i] == 4'h0);
      blank_mask[i] = upper_zero;
    end
  end
`else
  assign blank_mask = '0;
`endif

  assign seg_show = {~disp_point[idx], blank_mask[idx] ? SEG_GLYPH_OFF : glyph};

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_OFF;
      idx            <= '0;
      cnt            <= '0;
      pend_value     <= '0;
      pend_point     <= '0;
      disp_value     <= '0;
      disp_point     <= '0;
      loadBusy       <= 1'b0;
      frameStart     <= 1'b0;
      segmentEnableN <= SEG_DARK;
      digitEnableN   <= '1;
    end else begin
      // Drive pins from the current state so they trail it by one cycle.
      segmentEnableN <= (state == ST_SHOW) ? seg_show : SEG_DARK;
      digitEnableN   <= (state == ST_SHOW) ? ~(DIGIT_COUNT'(1) << idx) : '1;
      frameStart     <= commit;

      if (load) begin
        pend_value <= value;
        pend_point <= pointEnable;
      end
      // Commit moves the old pending copy; a coincident load refills it.
      if (commit) begin
        disp_value <= pend_value;
        disp_point <= pend_point;
        loadBusy   <= load;
      end else if (load) begin
        loadBusy   <= 1'b1;
      end

      if (!enable) begin
        state <= ST_OFF;
        idx   <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          ST_OFF: begin
            state <= ST_BLANK;
            idx   <= '0;
            cnt   <= '0;
          end
          ST_BLANK: begin
            if (cnt == BLANK_LAST) begin
              state <= ST_SHOW;
              cnt   <= '0;
            end else begin
              cnt   <= cnt + 1'b1;
            end
          end
          ST_SHOW: begin
            if (slot_end) begin
              state <= ST_BLANK;
              idx   <= idx_next;
              cnt   <= '0;
            end else begin
              cnt   <= cnt + 1'b1;
            end
          end
          default: begin
            state <= ST_OFF;
            idx   <= '0;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner (4 digits, 8-cycle slots,
// 2 blank cycles). Expected slot contents are queued at each frame start
// and checked against each lit slot as it appears.
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        reset, enable, load;
  logic [15:0] value;
  logic [3:0]  pointEnable;
  logic        loadBusy, frameStart;
  logic [7:0]  segmentEnableN;
  logic [3:0]  digitEnableN;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .DIGIT_COUNT    (4),
    .REFRESH_DIVIDE (8),
    .BLANK_CYCLES   (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .value          (value),
    .pointEnable    (pointEnable),
    .load           (load),
    .loadBusy       (loadBusy),
    .segmentEnableN (segmentEnableN),
    .digitEnableN   (digitEnableN),
    .frameStart     (frameStart)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [11:0] exp_q[$];
  logic [15:0] m_pend = '0, m_disp = '0;
  logic [3:0]  m_ppt = '0, m_dpt = '0;
  logic        m_busy = 1'b0;
  bit          mon_on = 1'b0;
  int          lit_len = 0, dark_len = 0;
  bit          seen_lit = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] seg_code(input logic [3:0] n);
    logic [7:0] c;
    case (n)
      4'h0: c = 8'hC0; 4'h1: c = 8'hF9; 4'h2: c = 8'hA4; 4'h3: c = 8'hB0;
      4'h4: c = 8'h99; 4'h5: c = 8'h92; 4'h6: c = 8'h82; 4'h7: c = 8'hF8;
      4'h8: c = 8'h80; 4'h9: c = 8'h90; 4'hA: c = 8'h88; 4'hB: c = 8'h83;
      4'hC: c = 8'hC6; 4'hD: c = 8'hA1; 4'hE: c = 8'h86; default: c = 8'h8E;
    endcase
    return c;
  endfunction

  // Queue the four slots of a frame showing m_disp/m_dpt, digit 0 first.
  task automatic push_frame();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] s;
      logic       blank;
      blank = 1'b0;
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
      blank = (i != 0) && ((m_disp >> (4 * i)) == 16'h0);
`endif
      s = blank ? 8'hFF : seg_code(m_disp[4*i +: 4]);
      if (m_dpt[i]) s[7] = 1'b0;
      exp_q.push_back({~(4'b0001 << i), s});
    end
  endtask

  // Wait (bounded) for frameStart, update the model, then check the pulse
  // is one cycle wide and loadBusy has cleared.
  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frameStart !== 1'b1 && n < 200);
    check("frame_start_seen", 32'(frameStart), 32'd1);
    m_disp = m_pend;
    m_dpt  = m_ppt;
    m_busy = 1'b0;
    push_frame();
    @(negedge clk);
    check("frame_pulse_width", 32'(frameStart), 32'd0);
    check("busy_after_commit", 32'(loadBusy), 32'(m_busy));
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] p);
    value = v; pointEnable = p; load = 1'b1;
    m_pend = v; m_ppt = p; m_busy = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Slot monitor: pops one expectation per lit slot, checks slot length and
  // dark gap between slots.
  always @(negedge clk) begin
    if (!mon_on) begin
      lit_len = 0; dark_len = 0; seen_lit = 1'b0;
    end else if (digitEnableN != 4'hF) begin
      if (lit_len == 0) begin
        if (seen_lit) check("dark_gap", 32'(dark_len), 32'd2);
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL slot_queue: observed empty queue expected pending slot, dig=%b seg=%h",
                 digitEnableN, segmentEnableN);
        end
        if (exp_q.size() != 0)
          check("slot_content", 32'({digitEnableN, segmentEnableN}), 32'(exp_q.pop_front()));
        seen_lit = 1'b1;
      end
      lit_len++;
      dark_len = 0;
    end else begin
      if (lit_len != 0) check("slot_length", 32'(lit_len), 32'd6);
      lit_len = 0;
      dark_len++;
    end
  end

  initial begin
    int n;
    reset = 1'b1; enable = 1'b0; load = 1'b0; value = '0; pointEnable = '0;

    // Reset overrides enable and load.
    @(negedge clk);
    enable = 1'b1; load = 1'b1; value = 16'hDEAD; pointEnable = 4'hF;
    repeat (2) @(negedge clk);
    check("rst_seg", 32'(segmentEnableN), 32'hFF);
    check("rst_dig", 32'(digitEnableN), 32'hF);
    check("rst_busy", 32'(loadBusy), 32'd0);
    check("rst_fs", 32'(frameStart), 32'd0);
    enable = 1'b0; load = 1'b0; reset = 1'b0;
    repeat (2) @(negedge clk);

    // Load while disabled, then enable: first commit shows 1234.
    do_load(16'h1234, 4'b0000);
    check("busy_after_load", 32'(loadBusy), 32'd1);
    check("dark_while_off", 32'(digitEnableN), 32'hF);
    enable = 1'b1;
    mon_on = 1'b1;
    wait_frame(n);
    wait_frame(n);
    check("frame_period", 32'(n + 1), 32'd32);

    // Mid-frame load: pending until the next frame start.
    repeat (9) @(negedge clk);
    do_load(16'hABCD, 4'b0000);
    check("busy_midframe", 32'(loadBusy), 32'd1);
    wait_frame(n);

    // Two loads in a frame, then one coincident with the commit.
    repeat (4) @(negedge clk);
    do_load(16'h1111, 4'b0000);
    repeat (4) @(negedge clk);
    do_load(16'h2222, 4'b0000);
    repeat (20) @(negedge clk);
    value = 16'h5678; pointEnable = 4'b1001; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("coincident_fs", 32'(frameStart), 32'd1);
    check("coincident_busy", 32'(loadBusy), 32'd1);
    m_disp = m_pend; m_dpt = m_ppt;
    push_frame();
    m_pend = 16'h5678; m_ppt = 4'b1001; m_busy = 1'b1;
    wait_frame(n);

    // Drop enable in digit 0's SHOW slot.
    repeat (4) @(negedge clk);
    mon_on = 1'b0;
    exp_q.delete();
    enable = 1'b0;
    @(negedge clk);
    check("disable_lag_dig", 32'(digitEnableN), 32'hE);
    @(negedge clk);
    check("disable_dark_dig", 32'(digitEnableN), 32'hF);
    check("disable_dark_seg", 32'(segmentEnableN), 32'hFF);
    repeat (3) @(negedge clk);
    check("disable_busy", 32'(loadBusy), 32'd0);
    enable = 1'b1;
    mon_on = 1'b1;
    wait_frame(n);

    // Leading-zero case with a point on a zero digit.
    repeat (9) @(negedge clk);
    do_load(16'h0070, 4'b0100);
    check("busy_lz", 32'(loadBusy), 32'd1);
    wait_frame(n);

    // Reset mid-SHOW with load high.
    repeat (4) @(negedge clk);
    mon_on = 1'b0;
    exp_q.delete();
    reset = 1'b1; load = 1'b1; value = 16'hFFFF; pointEnable = 4'hF;
    @(negedge clk);
    check("midrst_seg", 32'(segmentEnableN), 32'hFF);
    check("midrst_dig", 32'(digitEnableN), 32'hF);
    check("midrst_busy", 32'(loadBusy), 32'd0);
    check("midrst_fs", 32'(frameStart), 32'd0);
    reset = 1'b0; load = 1'b0;
    m_pend = '0; m_ppt = '0; m_busy = 1'b0;
    mon_on = 1'b1;
    wait_frame(n);

    repeat (29) @(negedge clk);
    mon_on = 1'b0;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
